// File: rtl/axis_maxpool_engine.sv
// Purpose: optional 2x2 stride-2 per-channel signed max-pool over a raster AXI-Stream, else pass-through.
// Latency: 1 cycle from the producing input beat to m_axis_tvalid.
// Backpressure: single output register; s_axis_tready = !m_axis_tvalid || m_axis_tready, no data loss.
module axis_maxpool_engine #(
    parameter int WORD_WIDTH = 8,
    parameter int CHANNELS   = 16,
    parameter int MAX_COLS   = 384
) (
    input  logic                           aclk,
    input  logic                           aresetn,
    input  logic                           s_axis_tvalid,
    output logic                           s_axis_tready,
    input  logic [CHANNELS*WORD_WIDTH-1:0] s_axis_tdata,
    input  logic                           s_axis_tlast,
    input  logic [2:0]                     s_axis_tuser,
    output logic                           m_axis_tvalid,
    input  logic                           m_axis_tready,
    output logic [CHANNELS*WORD_WIDTH-1:0] m_axis_tdata,
    output logic                           m_axis_tlast,
    output logic                           overflow_err
);
    localparam int DW       = CHANNELS * WORD_WIDTH;
    localparam int CW       = (MAX_COLS > 1) ? $clog2(MAX_COLS) : 1;
    localparam int LB_DEPTH = (MAX_COLS + 1) / 2;
    localparam int LBW      = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;
    localparam logic [CW-1:0] COL_MAX = CW'(MAX_COLS - 1);

    // Per-channel signed maximum of two packed pixels.
    function automatic logic [DW-1:0] vmax(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW-1:0] r;
        r = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            r[c*WORD_WIDTH +: WORD_WIDTH] =
                ($signed(a[c*WORD_WIDTH +: WORD_WIDTH]) > $signed(b[c*WORD_WIDTH +: WORD_WIDTH]))
                ? a[c*WORD_WIDTH +: WORD_WIDTH] : b[c*WORD_WIDTH +: WORD_WIDTH];
        end
        return r;
    endfunction

    logic [CW-1:0]  col;
    logic           col_sat;     // row ran past MAX_COLS; remaining beats of the row are dropped in pool mode
    logic           parity;
    logic           pair_valid;
    logic [DW-1:0]  pair_dat;
    logic           in_frame;    // a frame has started and its tlast has not yet been accepted
    logic           pool_q;      // pool_en latched on the first beat of the frame
    logic [DW-1:0]  lbuf [LB_DEPTH];

    logic           acc;
    logic           row_end;
    logic           last_row;
    logic           pool_mode;
    logic           col_even;
    logic [LBW-1:0] lb_idx;
    logic [DW-1:0]  h_dat;
    logic           out_vld_n;
    logic [DW-1:0]  out_dat_n;
    logic           lb_wr;

    assign s_axis_tready = aresetn && (!m_axis_tvalid || m_axis_tready);
    assign acc       = s_axis_tvalid && s_axis_tready;
    // A tlast without row_last still closes the row.
    assign row_end   = s_axis_tuser[1] || s_axis_tlast;
    assign last_row  = s_axis_tuser[2];
    assign pool_mode = in_frame ? pool_q : s_axis_tuser[0];
    assign col_even  = ~col[0];
    assign lb_idx    = LBW'(col >> 1);
    // Odd-width rows end on an even column with no partner: the pixel pairs with itself.
    assign h_dat     = pair_valid ? vmax(pair_dat, s_axis_tdata) : s_axis_tdata;

    // Decide what the current beat would produce: an output, a line-buffer write, or nothing.
    always_comb begin
        out_vld_n = 1'b0;
        out_dat_n = s_axis_tdata;
        lb_wr     = 1'b0;
        if (!pool_mode) begin
            out_vld_n = 1'b1;
        end else if (!col_sat && (!col_even || row_end)) begin
            if (parity) begin
                out_vld_n = 1'b1;
                out_dat_n = vmax(lbuf[lb_idx], h_dat);
            end else if (last_row) begin
                out_vld_n = 1'b1;
                out_dat_n = h_dat;
            end else begin
                lb_wr = 1'b1;
            end
        end
    end

    // Even rows park their horizontal maxima here for the following odd row.
    always_ff @(posedge aclk) begin
        if (acc && lb_wr) begin
            lbuf[lb_idx] <= h_dat;
        end
    end

    // Frame, row and column tracking plus the horizontal pair register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            col          <= '0;
            col_sat      <= 1'b0;
            parity       <= 1'b0;
            pair_valid   <= 1'b0;
            pair_dat     <= '0;
            in_frame     <= 1'b0;
            pool_q       <= 1'b0;
            overflow_err <= 1'b0;
        end else if (acc) begin
            if (!in_frame) begin
                pool_q <= s_axis_tuser[0];
            end
            in_frame <= !s_axis_tlast;
            if (pool_mode && !col_sat) begin
                if (col_even && !row_end) begin
                    pair_dat   <= s_axis_tdata;
                    pair_valid <= 1'b1;
                end else begin
                    pair_valid <= 1'b0;
                end
            end
            if (row_end) begin
                col        <= '0;
                col_sat    <= 1'b0;
                pair_valid <= 1'b0;
                parity     <= s_axis_tlast ? 1'b0 : ~parity;
            end else if (col == COL_MAX) begin
                col_sat      <= 1'b1;
                overflow_err <= 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // Output register: load on a producing beat, otherwise drain when downstream is ready.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
        end else if (acc && out_vld_n) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= out_dat_n;
            m_axis_tlast  <= s_axis_tlast;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_axis_maxpool_engine.sv
// Purpose: randomized and directed check of axis_maxpool_engine against a frame-level pooling model.
// Latency: outputs matched in order against an expected queue, independent of cycle timing.
// Backpressure: downstream ready is randomized; held data and the ready rule are checked every cycle.
module tb_axis_maxpool_engine;
    localparam int WW = 8;
    localparam int CH = 16;
    localparam int DW = WW * CH;
    localparam int MC = 8;
    localparam int MAXH = 6;

    logic          aclk = 1'b0;
    logic          aresetn;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic [DW-1:0] s_axis_tdata;
    logic          s_axis_tlast;
    logic [2:0]    s_axis_tuser;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tlast;
    logic          overflow_err;

    axis_maxpool_engine #(.WORD_WIDTH(WW), .CHANNELS(CH), .MAX_COLS(MC)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
        .overflow_err(overflow_err)
    );

    always #5 aclk = ~aclk;

    int n_tests = 0;
    int n_fail  = 0;
    int rdy_pct = 100;
    logic [DW-1:0] fpix [MAXH][MC];
    logic [DW-1:0] exp_dat [$];
    logic          exp_last [$];

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] pmax(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW-1:0] r;
        logic signed [WW-1:0] x, y;
        r = '0;
        for (int c = 0; c < CH; c++) begin
            x = a[c*WW +: WW];
            y = b[c*WW +: WW];
            r[c*WW +: WW] = (x > y) ? x : y;
        end
        return r;
    endfunction

    function automatic logic [DW-1:0] rnd_pix();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Downstream ready, changed only on the falling edge.
    always @(negedge aclk) m_axis_tready <= ($urandom_range(99) < rdy_pct);

    // Monitor: sample well after the falling edge, i.e. the values seen by the next rising edge.
    logic          stall_prev = 1'b0;
    logic [DW-1:0] stall_dat;
    logic          stall_last;
    always @(negedge aclk) begin
        #2;
        if (aresetn) begin
            chk("rdy_rule", DW'(s_axis_tready), DW'(!m_axis_tvalid || m_axis_tready));
            if (stall_prev) begin
                chk("hold_vld", DW'(m_axis_tvalid), DW'(1));
                chk("hold_dat", m_axis_tdata, stall_dat);
                chk("hold_last", DW'(m_axis_tlast), DW'(stall_last));
            end
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_dat.size() == 0) begin
                    chk("unexpected_out", DW'(1), DW'(0));
                end else begin
                    chk("out_dat", m_axis_tdata, exp_dat.pop_front());
                    chk("out_last", DW'(m_axis_tlast), DW'(exp_last.pop_front()));
                end
            end
            stall_prev = m_axis_tvalid && !m_axis_tready;
            stall_dat  = m_axis_tdata;
            stall_last = m_axis_tlast;
        end else begin
            stall_prev = 1'b0;
        end
    end

    // Drive one beat starting at a falling edge; returns at the falling edge after acceptance.
    task automatic send_beat(input logic [DW-1:0] d, input logic [2:0] u, input logic l);
        bit r;
        int n;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tuser  = u;
        s_axis_tlast  = l;
        n = 0;
        forever begin
            #1;
            r = s_axis_tready;
            @(posedge aclk);
            if (r) break;
            n++;
            if (n > 1000) begin
                chk("accept_timeout", DW'(0), DW'(1));
                break;
            end
            @(negedge aclk);
        end
        @(negedge aclk);
    endtask

    // Reference: whole-frame view, each output is the max over its (clipped) 2x2 window.
    task automatic model_frame(input int w, input int h, input bit pool);
        logic [DW-1:0] m;
        if (!pool) begin
            for (int r = 0; r < h; r++)
                for (int c = 0; c < w; c++) begin
                    exp_dat.push_back(fpix[r][c]);
                    exp_last.push_back(r == h - 1 && c == w - 1);
                end
        end else begin
            for (int r = 0; r < h; r += 2)
                for (int c = 0; c < w; c += 2) begin
                    m = fpix[r][c];
                    for (int rr = r; rr <= r + 1 && rr < h; rr++)
                        for (int cc = c; cc <= c + 1 && cc < w; cc++)
                            m = pmax(m, fpix[rr][cc]);
                    exp_dat.push_back(m);
                    exp_last.push_back(r + 2 >= h && c + 2 >= w);
                end
        end
    endtask

    task automatic run_frame(input int w, input int h, input bit pool);
        logic p;
        model_frame(w, h, pool);
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++) begin
                p = (r == 0 && c == 0) ? pool : 1'($urandom);
                send_beat(fpix[r][c], {r == h - 1, c == w - 1, p}, r == h - 1 && c == w - 1);
            end
        s_axis_tvalid = 1'b0;
    endtask

    task automatic fill_random(input int w, input int h);
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++) fpix[r][c] = rnd_pix();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_dat.size() != 0 && n < 2000) begin
            @(negedge aclk);
            n++;
        end
        chk("drain", DW'(exp_dat.size()), DW'(0));
        repeat (3) @(negedge aclk);
    endtask

    task automatic set_ch0_4x2();
        logic signed [WW-1:0] v [8];
        v = '{1, -5, 3, 7, 2, 0, -8, 6};
        fill_random(4, 2);
        for (int i = 0; i < 8; i++) fpix[i / 4][i % 4][WW-1:0] = v[i];
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_tvalid"}, DW'(m_axis_tvalid), DW'(0));
        chk({tag, "_tlast"}, DW'(m_axis_tlast), DW'(0));
        chk({tag, "_tdata"}, m_axis_tdata, DW'(0));
        chk({tag, "_ovf"}, DW'(overflow_err), DW'(0));
        chk({tag, "_tready"}, DW'(s_axis_tready), DW'(0));
    endtask

    initial begin
        logic signed [WW-1:0] ext [4];
        aresetn = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata = '0;
        s_axis_tuser = '0;
        s_axis_tlast = 1'b0;
        m_axis_tready = 1'b1;
        repeat (3) @(negedge aclk);
        chk_reset_state("rst");
        aresetn = 1'b1;
        @(negedge aclk);

        // Pass-through 1,2,3,4.
        fill_random(4, 1);
        for (int c = 0; c < 4; c++) fpix[0][c][WW-1:0] = WW'(c + 1);
        run_frame(4, 1, 1'b0);
        drain();

        // 4x2 pooling -> 2, 7.
        set_ch0_4x2();
        run_frame(4, 2, 1'b1);
        drain();

        // 3x3 ceil mode -> 5, 6, 8, 9.
        fill_random(3, 3);
        for (int i = 0; i < 9; i++) fpix[i / 3][i % 3][WW-1:0] = WW'(i + 1);
        run_frame(3, 3, 1'b1);
        drain();

        // Signed extremes, then all -128.
        ext = '{-128, 127, -1, 0};
        fill_random(2, 2);
        for (int i = 0; i < 4; i++) fpix[i / 2][i % 2][WW-1:0] = ext[i];
        run_frame(2, 2, 1'b1);
        for (int i = 0; i < 4; i++) fpix[i / 2][i % 2] = {CH{8'h80}};
        run_frame(2, 2, 1'b1);
        drain();

        // Backpressure on the 4x2 case.
        rdy_pct = 30;
        set_ch0_4x2();
        run_frame(4, 2, 1'b1);
        drain();

        // Random back-to-back frames with random ready.
        for (int f = 0; f < 24; f++) begin
            int w, h;
            rdy_pct = (f % 3 == 0) ? 100 : 60;
            w = $urandom_range(MC, 1);
            h = $urandom_range(MAXH, 1);
            fill_random(w, h);
            run_frame(w, h, 1'($urandom));
        end
        drain();
        chk("no_ovf_yet", DW'(overflow_err), DW'(0));

        // Overflow: 11 beats in one row with MAX_COLS=8, pass-through keeps every beat.
        rdy_pct = 100;
        for (int i = 0; i < 11; i++) begin
            logic [DW-1:0] d;
            d = rnd_pix();
            exp_dat.push_back(d);
            exp_last.push_back(i == 10);
            send_beat(d, {i == 10, i == 10, 1'b0}, i == 10);
        end
        s_axis_tvalid = 1'b0;
        drain();
        chk("ovf_set", DW'(overflow_err), DW'(1));
        fill_random(2, 2);
        run_frame(2, 2, 1'b1);
        drain();
        chk("ovf_sticky", DW'(overflow_err), DW'(1));

        // Reset mid-frame (row 0 of a pooled frame produces no output), then pool a fresh 4x2.
        set_ch0_4x2();
        for (int c = 0; c < 3; c++) send_beat(fpix[0][c], {2'b00, 1'b1}, 1'b0);
        s_axis_tvalid = 1'b0;
        #3;
        aresetn = 1'b0;
        #1;
        chk_reset_state("midrst");
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        set_ch0_4x2();
        run_frame(4, 2, 1'b1);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
